// File: rtl/key_event_pkg.sv
// Shared types, default timing and sizing helper for the panel key conditioning block.
package key_event_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        REPEAT,
        REL_CHK
    } key_fsm_t;

    localparam int DEF_F_CLK          = 50_000_000;
    localparam int DEF_F_TICK         = 1000;
    localparam int DEF_N_KEYS         = 6;
    localparam int DEF_DEBOUNCE_TICKS = 20;
    localparam int DEF_LONG_TICKS     = 500;
    localparam int DEF_REPEAT_TICKS   = 100;

    // Width that holds every terminal count; counters clear at their terminal value.
    function automatic int cnt_width(input int deb, input int long_t, input int rpt);
        int m;
        m = deb;
        if (long_t > m) m = long_t;
        if (rpt > m) m = rpt;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/key_tick_gen.sv
// Divides clk down to a single-cycle tick at F_TICK, shared by every key debouncer.
module key_tick_gen #(
    parameter int F_CLK  = 50_000_000,
    parameter int F_TICK = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DIV = F_CLK / F_TICK;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/key_event_gen.sv
// Synchronises and debounces active-low panel keys and emits press, release and
// auto-repeat pulses in the clk domain.
module key_event_gen
    import key_event_pkg::*;
#(
    parameter int F_CLK          = DEF_F_CLK,
    parameter int F_TICK         = DEF_F_TICK,
    parameter int N_KEYS         = DEF_N_KEYS,
    parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
    parameter int LONG_TICKS     = DEF_LONG_TICKS,
    parameter int REPEAT_TICKS   = DEF_REPEAT_TICKS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key,
    output logic [N_KEYS-1:0] key_state,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_repeat,
    output logic              tick
);

    localparam int CNT_W = cnt_width(DEBOUNCE_TICKS, LONG_TICKS, REPEAT_TICKS);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_TICKS - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    key_tick_gen #(
        .F_CLK (F_CLK),
        .F_TICK(F_TICK)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    logic [N_KEYS-1:0] sync_p0, sync_p1;

    // Stage p0/p1: two-flop synchroniser, idles at the released level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= '1;
            sync_p1 <= '1;
        end else begin
            sync_p0 <= key;
            sync_p1 <= sync_p0;
        end
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_fsm_t         state_q, state_d;
        logic [CNT_W-1:0] deb_q, deb_d, hold_q, hold_d;
        logic             from_rpt_q, from_rpt_d;
        logic             level_q, level_d;
        logic             press_q, press_d, rls_q, rls_d, rpt_q, rpt_d;
        logic             ks;

        assign ks = sync_p1[i];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q    <= IDLE;
                deb_q      <= '0;
                hold_q     <= '0;
                from_rpt_q <= 1'b0;
                level_q    <= 1'b1;
                press_q    <= 1'b0;
                rls_q      <= 1'b0;
                rpt_q      <= 1'b0;
            end else begin
                state_q    <= state_d;
                deb_q      <= deb_d;
                hold_q     <= hold_d;
                from_rpt_q <= from_rpt_d;
                level_q    <= level_d;
                press_q    <= press_d;
                rls_q      <= rls_d;
                rpt_q      <= rpt_d;
            end
        end

        // A ks change is checked before tick so a coincident tick is dropped for this key.
        always_comb begin
            state_d    = state_q;
            deb_d      = deb_q;
            hold_d     = hold_q;
            from_rpt_d = from_rpt_q;
            level_d    = level_q;
            press_d    = 1'b0;
            rls_d      = 1'b0;
            rpt_d      = 1'b0;
            case (state_q)
                IDLE: begin
                    if (!ks) begin
                        state_d = PRESS_CHK;
                        deb_d   = '0;
                    end
                end
                PRESS_CHK: begin
                    if (ks) begin
                        state_d = IDLE;
                    end else if (tick) begin
                        if (deb_q == DEB_LAST) begin
                            state_d = HELD;
                            level_d = 1'b0;
                            press_d = 1'b1;
                            hold_d  = '0;
                        end else begin
                            deb_d = deb_q + CNT_ONE;
                        end
                    end
                end
                HELD: begin
                    if (ks) begin
                        state_d    = REL_CHK;
                        from_rpt_d = 1'b0;
                        deb_d      = '0;
                    end else if (tick) begin
                        if (hold_q == LONG_LAST) begin
                            state_d = REPEAT;
                            rpt_d   = 1'b1;
                            hold_d  = '0;
                        end else begin
                            hold_d = hold_q + CNT_ONE;
                        end
                    end
                end
                REPEAT: begin
                    if (ks) begin
                        state_d    = REL_CHK;
                        from_rpt_d = 1'b1;
                        deb_d      = '0;
                    end else if (tick) begin
                        if (hold_q == RPT_LAST) begin
                            rpt_d  = 1'b1;
                            hold_d = '0;
                        end else begin
                            hold_d = hold_q + CNT_ONE;
                        end
                    end
                end
                REL_CHK: begin
                    // hold_q is left untouched so a rejected release resumes the hold timing
                    if (!ks) begin
                        state_d = from_rpt_q ? REPEAT : HELD;
                    end else if (tick) begin
                        if (deb_q == DEB_LAST) begin
                            state_d = IDLE;
                            level_d = 1'b1;
                            rls_d   = 1'b1;
                        end else begin
                            deb_d = deb_q + CNT_ONE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        assign key_state[i]   = level_q;
        assign key_press[i]   = press_q;
        assign key_release[i] = rls_q;
        assign key_repeat[i]  = rpt_q;
    end

endmodule

// File: tb/tb_key_event_gen.sv
// Randomised and directed bench for key_event_gen against a tick-counting reference model.
module tb_key_event_gen;

    localparam int F_CLK  = 10000;
    localparam int F_TICK = 1000;
    localparam int N_KEYS = 2;
    localparam int DEB    = 3;
    localparam int LONG   = 5;
    localparam int REP    = 2;
    localparam int DIV    = F_CLK / F_TICK;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N_KEYS-1:0] key = '1;
    logic [N_KEYS-1:0] key_state, key_press, key_release, key_repeat;
    logic              tick;

    always #5 clk = ~clk;

    key_event_gen #(
        .F_CLK         (F_CLK),
        .F_TICK        (F_TICK),
        .N_KEYS        (N_KEYS),
        .DEBOUNCE_TICKS(DEB),
        .LONG_TICKS    (LONG),
        .REPEAT_TICKS  (REP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key        (key),
        .key_state  (key_state),
        .key_press  (key_press),
        .key_release(key_release),
        .key_repeat (key_repeat),
        .tick       (tick)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: accepted level plus counts of qualifying ticks.
    logic [N_KEYS-1:0] m_lvl, m_prev, m_s0, m_s1;
    logic [N_KEYS-1:0] e_press, e_rel, e_rep;
    int                m_run [N_KEYS];
    int                m_held[N_KEYS];
    int                m_tc;
    int                n_press[N_KEYS], n_rel[N_KEYS], n_rep[N_KEYS];

    task automatic model_reset();
        m_lvl   = '1;
        m_prev  = '1;
        m_s0    = '1;
        m_s1    = '1;
        m_tc    = 0;
        e_press = '0;
        e_rel   = '0;
        e_rep   = '0;
        for (int k = 0; k < N_KEYS; k++) begin
            m_run[k]  = 0;
            m_held[k] = 0;
        end
    endtask

    task automatic clr_cnt();
        for (int k = 0; k < N_KEYS; k++) begin
            n_press[k] = 0;
            n_rel[k]   = 0;
            n_rep[k]   = 0;
        end
    endtask

    // A tick counts only if ks held its value in the previous cycle as well.
    task automatic model_step();
        logic t;
        t       = (m_tc == DIV - 1);
        e_press = '0;
        e_rel   = '0;
        e_rep   = '0;
        for (int k = 0; k < N_KEYS; k++) begin
            logic ks, lvl0;
            ks   = m_s1[k];
            lvl0 = m_lvl[k];
            if (ks != lvl0) begin
                if (m_prev[k] != lvl0 && t) begin
                    m_run[k]++;
                    if (m_run[k] == DEB) begin
                        m_lvl[k] = ks;
                        m_run[k] = 0;
                        if (!ks) begin
                            e_press[k] = 1'b1;
                            m_held[k]  = 0;
                        end else begin
                            e_rel[k] = 1'b1;
                        end
                    end
                end
            end else begin
                m_run[k] = 0;
            end
            if (!lvl0 && !ks && !m_prev[k] && t) begin
                m_held[k]++;
                if (m_held[k] == LONG || (m_held[k] > LONG && (m_held[k] - LONG) % REP == 0))
                    e_rep[k] = 1'b1;
            end
            m_prev[k] = ks;
        end
        m_s1 = m_s0;
        m_s0 = key;
        m_tc = (m_tc + 1) % DIV;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
        chk("key_state", 32'(key_state), 32'(m_lvl));
        chk("key_press", 32'(key_press), 32'(e_press));
        chk("key_release", 32'(key_release), 32'(e_rel));
        chk("key_repeat", 32'(key_repeat), 32'(e_rep));
        chk("tick", 32'(tick), 32'(m_tc == DIV - 1));
        for (int k = 0; k < N_KEYS; k++) begin
            if (key_press[k]) n_press[k]++;
            if (key_release[k]) n_rel[k]++;
            if (key_repeat[k]) n_rep[k]++;
        end
    endtask

    initial begin
        int p, r, r1, r2, t1, t2, rp;
        logic both, split;
        int left[N_KEYS];

        model_reset();
        clr_cnt();
        repeat (2) cycle();
        chk("reset_key_state", 32'(key_state), 32'(2'b11));
        chk("reset_pulses", 32'({key_press, key_release, key_repeat}), 32'(0));
        chk("reset_tick", 32'(tick), 32'(0));
        rst = 1'b0;

        // Tick is high in the tenth clock period after release, seen after the ninth edge.
        t1 = -1;
        t2 = -1;
        for (int i = 1; i <= 25; i++) begin
            cycle();
            if (tick && t1 < 0) t1 = i;
            else if (tick && t2 < 0) t2 = i;
        end
        chk("first_tick_edge", 32'(t1), 32'(9));
        chk("tick_period", 32'(t2 - t1), 32'(DIV));

        // Clean press and release on key 0
        clr_cnt();
        key[0] = 1'b0;
        p = -1;
        for (int i = 1; i <= 40; i++) begin
            cycle();
            if (key_press[0] && p < 0) p = i;
        end
        chk("s2_press_count", 32'(n_press[0]), 32'(1));
        chk("s2_press_latency", 32'(p >= 24 && p <= 33), 32'(1));
        chk("s2_key1_quiet", 32'(n_press[1] + n_rel[1] + n_rep[1]), 32'(0));
        chk("s2_level", 32'(key_state), 32'(2'b10));
        key[0] = 1'b1;
        r = -1;
        for (int i = 1; i <= 45; i++) begin
            cycle();
            if (key_release[0] && r < 0) r = i;
        end
        chk("s2_release_latency", 32'(r >= 24 && r <= 33), 32'(1));
        chk("s2_release_count", 32'(n_rel[0]), 32'(1));
        chk("s2_no_repeat", 32'(n_rep[0]), 32'(0));

        // Bounce rejection
        clr_cnt();
        key[0] = 1'b0; repeat (15) cycle();
        key[0] = 1'b1; repeat (5) cycle();
        key[0] = 1'b0; repeat (15) cycle();
        key[0] = 1'b1; repeat (40) cycle();
        chk("s3_no_press", 32'(n_press[0]), 32'(0));
        chk("s3_no_release", 32'(n_rel[0]), 32'(0));
        chk("s3_level", 32'(key_state), 32'(2'b11));

        // Long press with auto-repeat
        clr_cnt();
        key[0] = 1'b0;
        p = -1; r1 = -1; r2 = -1;
        for (int i = 1; i <= 150; i++) begin
            cycle();
            if (key_press[0] && p < 0) p = i;
            if (key_repeat[0]) begin
                if (r1 < 0) r1 = i;
                else if (r2 < 0) r2 = i;
            end
        end
        key[0] = 1'b1;
        r = -1;
        for (int i = 1; i <= 45; i++) begin
            cycle();
            if (key_release[0] && r < 0) r = i;
        end
        chk("s4_press_count", 32'(n_press[0]), 32'(1));
        chk("s4_first_repeat", 32'(r1 - p), 32'(LONG * DIV));
        chk("s4_repeat_period", 32'(r2 - r1), 32'(REP * DIV));
        chk("s4_repeat_count", 32'(n_rep[0]), 32'(4));
        chk("s4_release_latency", 32'(r >= 24 && r <= 33), 32'(1));
        chk("s4_release_count", 32'(n_rel[0]), 32'(1));

        // Release glitch while held: one tick is frozen, first repeat moves out by one period
        clr_cnt();
        key[0] = 1'b0;
        p = -1;
        for (int i = 1; i <= 40 && p < 0; i++) begin
            cycle();
            if (key_press[0]) p = i;
        end
        chk("s5_press_seen", 32'(p > 0), 32'(1));
        key[0] = 1'b1; repeat (12) cycle();
        key[0] = 1'b0;
        rp = -1;
        for (int i = 1; i <= 80; i++) begin
            cycle();
            if (key_repeat[0] && rp < 0) rp = i;
        end
        chk("s5_repeat_delay", 32'(12 + rp), 32'((LONG + 1) * DIV));
        chk("s5_no_release", 32'(n_rel[0]), 32'(0));
        chk("s5_level", 32'(key_state[0]), 32'(0));
        key[0] = 1'b1; repeat (45) cycle();

        // Simultaneous press and release on both keys
        clr_cnt();
        key = 2'b00;
        both = 1'b0; split = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            cycle();
            if (key_press == 2'b11) both = 1'b1;
            if (key_press == 2'b01 || key_press == 2'b10) split = 1'b1;
        end
        chk("s6_press_both", 32'(both), 32'(1));
        chk("s6_press_split", 32'(split), 32'(0));
        key = 2'b11;
        both = 1'b0; split = 1'b0;
        for (int i = 1; i <= 45; i++) begin
            cycle();
            if (key_release == 2'b11) both = 1'b1;
            if (key_release == 2'b01 || key_release == 2'b10) split = 1'b1;
        end
        chk("s6_release_both", 32'(both), 32'(1));
        chk("s6_release_split", 32'(split), 32'(0));

        // Asynchronous reset while key 0 is held, then re-debounce
        clr_cnt();
        key[0] = 1'b0;
        repeat (40) cycle();
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_state", 32'(key_state), 32'(2'b11));
        chk("async_rst_pulses", 32'({key_press, key_release, key_repeat}), 32'(0));
        chk("async_rst_tick", 32'(tick), 32'(0));
        model_reset();
        clr_cnt();
        repeat (2) cycle();
        rst = 1'b0;
        t1 = -1; p = -1;
        for (int i = 1; i <= 40; i++) begin
            cycle();
            if (tick && t1 < 0) t1 = i;
            if (key_press[0] && p < 0) p = i;
        end
        chk("s1_first_tick", 32'(t1), 32'(9));
        chk("s1_repress_edge", 32'(p), 32'(3 * DIV));
        chk("s1_no_release", 32'(n_rel[0]), 32'(0));
        key[0] = 1'b1;
        repeat (45) cycle();

        // Random bounce and hold patterns on both keys
        for (int k = 0; k < N_KEYS; k++) left[k] = 1;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N_KEYS; k++) begin
                left[k]--;
                if (left[k] <= 0) begin
                    key[k] = ~key[k];
                    if ($urandom_range(0, 2) == 0) left[k] = int'($urandom_range(1, 8));
                    else left[k] = int'($urandom_range(15, 180));
                end
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
